// File: rtl/rcpu_io_responder.sv
// RCPU I/O-bus responder: UART TX FIFO + 8N1 serialiser, STATUS, TIMER, SCRATCH.
// Define RCPU_IO_TIMER_EN to build the free-running TIMER register at 0x0008.
module rcpu_io_responder #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [0:15] io_address,
    input  logic [0:15] io_write_data,
    output logic [0:15] io_read_data,
    output logic        uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Core numbers bits MSB-first; work internally in conventional LSB-0 order.
    logic [15:0] addr, wdata, rdata, rd_next;
    assign addr         = io_address;
    assign wdata        = io_write_data;
    assign io_read_data = rdata;

    logic wr_tx, wr_status;
    assign wr_tx     = io_write_enable && (addr == 16'h0000);
    assign wr_status = io_write_enable && (addr == 16'h0004);

    // TX FIFO with one extra pointer bit to tell full from empty
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, push, pop, ovf;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = wr_tx && !full;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (wr_tx && full)
                ovf <= 1'b1;
            else if (wr_status && wdata[0])
                ovf <= 1'b0;
        end
    end

    // Serialiser
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          last_clk;

    assign last_clk = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        pop       = 1'b0;
        uart_tx   = 1'b1;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = mem[rptr[AW-1:0]];
                    cnt_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (last_clk) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = S_DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DATA: begin
                uart_tx = shreg[0];
                if (last_clk) begin
                    cnt_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (last_clk) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef RCPU_IO_TIMER_EN
    logic [15:0] timer;
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            timer <= '0;
        else if (io_write_enable && (addr == 16'h0008))
            timer <= wdata;
        else
            timer <= timer + 16'd1;
    end
`endif

    logic [15:0] scratch;
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            scratch <= '0;
        else if (io_write_enable && (addr == 16'h000C))
            scratch <= wdata;
    end

    // Reads see pre-edge register values, so a same-cycle write is not visible yet
    always_comb begin
        rd_next = 16'h0000;
        case (addr)
            16'h0004: rd_next = {12'h000, ovf, (state != S_IDLE), full, empty};
`ifdef RCPU_IO_TIMER_EN
            16'h0008: rd_next = timer;
`endif
            16'h000C: rd_next = scratch;
            default:  rd_next = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            rdata <= '0;
        else if (io_read_enable)
            rdata <= rd_next;
    end
endmodule
